perceptron_bp_pipe: RTL



---
 rtl/perceptron_bp_pkg.sv | 41 ++++
 rtl/perceptron_bp_pipe_dot.sv | 27 ++
 rtl/perceptron_bp_pipe.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/perceptron_bp_pkg.sv
`default_nettype none
// ============================================================================
// perceptron_bp_pkg : shared types, trainer states and helpers for the
//                     perceptron branch predictor.            Rev 1.0
// ============================================================================
package perceptron_bp_pkg;

   // Container wide enough for any supported weight width; rows store W_WIDTH bits.
   localparam int MAX_W = 16;

   typedef logic signed [MAX_W-1:0]   weight_t;
   typedef logic signed [MAX_W+7:0]   sum_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      UPDATE = 2'd2
   } bp_train_state_e;

   function automatic weight_t sat_add(input weight_t w, input logic signed [1:0] step,
                                       input int width);
      int s;
      int hi;
      int lo;
      s  = int'(w) + int'(step);
      hi = (1 << (width - 1)) - 1;
      lo = -(1 << (width - 1));
      if (s > hi)
         s = hi;
      else if (s < lo)
         s = lo;
      return weight_t'(s);
   endfunction

   // Caller keeps the low IDX_W bits: pc[IDX_W+1:2] ^ ghr[IDX_W-1:0].
   function automatic logic [31:0] idx_hash(input logic [31:0] pc, input logic [31:0] ghr);
      return (pc >> 2) ^ ghr;
   endfunction

endpackage
`default_nettype wire

// File: rtl/perceptron_bp_pipe_dot.sv
`default_nettype none
// ============================================================================
// perceptron_dot : combinational signed dot product of one weight row with
//                  the +/-1 encoded history (bias input fixed at +1). Rev 1.0
// ============================================================================
module perceptron_dot #(
   parameter int HIST_LEN = 12,
   parameter int W_WIDTH  = 8,
   parameter int SUM_W    = W_WIDTH + $clog2(HIST_LEN + 1)
) (
   input  logic [HIST_LEN:0][W_WIDTH-1:0] row,
   input  logic [HIST_LEN-1:0]            ghr,
   output logic signed [SUM_W-1:0]        y
);

   always_comb begin
      y = {{(SUM_W-W_WIDTH){row[0][W_WIDTH-1]}}, row[0]};
      for (int i = 1; i <= HIST_LEN; i++) begin
         if (ghr[i-1])
            y = y + {{(SUM_W-W_WIDTH){row[i][W_WIDTH-1]}}, row[i]};
         else
            y = y - {{(SUM_W-W_WIDTH){row[i][W_WIDTH-1]}}, row[i]};
      end
   end

endmodule
`default_nettype wire

// File: rtl/perceptron_bp_pipe.sv
`default_nettype none
// ============================================================================
// perceptron_bp_pipe : global-history perceptron predictor with registered
//                      prediction, speculative GHR and FSM trainer.  Rev 1.0
// ============================================================================
module perceptron_bp_pipe
   import perceptron_bp_pkg::*;
#(
   parameter int PC_W     = 12,
   parameter int HIST_LEN = 12,
   parameter int ROWS     = 64,
   parameter int W_WIDTH  = 8,
   parameter int THETA    = 37
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pred_req,
   input  logic [PC_W-1:0]     pred_pc,
   output logic                pred_valid,
   output logic                pred_taken,
   output logic [HIST_LEN-1:0] pred_ghr,
   input  logic                res_valid,
   output logic                res_ready,
   input  logic [PC_W-1:0]     res_pc,
   input  logic [HIST_LEN-1:0] res_ghr,
   input  logic                res_taken,
   input  logic                res_mispredict,
   output logic                train_busy
);

   localparam int IDX_W = $clog2(ROWS);
   localparam int SUM_W = W_WIDTH + $clog2(HIST_LEN + 1);

   typedef logic [HIST_LEN:0][W_WIDTH-1:0] row_t;

   row_t                   r_table [ROWS];
   bp_train_state_e        r_state, w_state_next;
   logic [HIST_LEN-1:0]    r_ghr, r_pred_ghr, r_t_ghr;
   logic                   r_pred_valid, r_pred_taken, r_t_taken, r_t_mp;
   logic [PC_W-1:0]        r_t_pc;
   logic [IDX_W-1:0]       w_pred_idx, w_t_idx;
   row_t                   w_pred_row, w_t_row, w_new_row;
   logic signed [SUM_W-1:0] w_pred_y, w_t_y;
   int                     w_t_y_int;
   logic                   w_pred_taken, w_xfer, w_repair, w_pred_fire, w_train;

   assign w_pred_idx = IDX_W'(idx_hash(32'(pred_pc), 32'(r_ghr)));
   assign w_t_idx    = IDX_W'(idx_hash(32'(r_t_pc), 32'(r_t_ghr)));
   assign w_pred_row = r_table[w_pred_idx];
   assign w_t_row    = r_table[w_t_idx];

   perceptron_dot #(.HIST_LEN(HIST_LEN), .W_WIDTH(W_WIDTH), .SUM_W(SUM_W)) u_dot_pred (
      .row (w_pred_row),
      .ghr (r_ghr),
      .y   (w_pred_y)
   );

   perceptron_dot #(.HIST_LEN(HIST_LEN), .W_WIDTH(W_WIDTH), .SUM_W(SUM_W)) u_dot_train (
      .row (w_t_row),
      .ghr (r_t_ghr),
      .y   (w_t_y)
   );

   assign w_pred_taken = ~w_pred_y[SUM_W-1];
   assign res_ready    = (r_state == IDLE);
   assign train_busy   = ~res_ready;
   assign w_xfer       = res_valid & res_ready;
   assign w_repair     = w_xfer & res_mispredict;
   // A repair wins the GHR this cycle, so a concurrent prediction is dropped.
   assign w_pred_fire  = pred_req & ~w_repair;

   // Threshold compare done in 32 bits so a large THETA never truncates.
   assign w_t_y_int = int'(w_t_y);
   assign w_train   = r_t_mp | ((w_t_y_int <= THETA) & (w_t_y_int >= -THETA));

   assign w_new_row[0] = W_WIDTH'(sat_add(weight_t'(signed'(w_t_row[0])),
                                          r_t_taken ? 2'sb01 : 2'sb11, W_WIDTH));
   for (genvar i = 1; i <= HIST_LEN; i++) begin : g_update
      assign w_new_row[i] = W_WIDTH'(sat_add(weight_t'(signed'(w_t_row[i])),
                                             (r_t_taken == r_t_ghr[i-1]) ? 2'sb01 : 2'sb11,
                                             W_WIDTH));
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_xfer) w_state_next = CALC;
         CALC:    w_state_next = w_train ? UPDATE : IDLE;
         UPDATE:  w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= IDLE;
      else
         r_state <= w_state_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ghr        <= '0;
         r_pred_valid <= 1'b0;
         r_pred_taken <= 1'b0;
         r_pred_ghr   <= '0;
         r_t_pc       <= '0;
         r_t_ghr      <= '0;
         r_t_taken    <= 1'b0;
         r_t_mp       <= 1'b0;
      end else begin
         r_pred_valid <= w_pred_fire;
         if (w_pred_fire) begin
            r_pred_taken <= w_pred_taken;
            r_pred_ghr   <= r_ghr;
         end
         if (w_repair)
            r_ghr <= {res_ghr[HIST_LEN-2:0], res_taken};
         else if (pred_req)
            r_ghr <= {r_ghr[HIST_LEN-2:0], w_pred_taken};
         if (w_xfer) begin
            r_t_pc    <= res_pc;
            r_t_ghr   <= res_ghr;
            r_t_taken <= res_taken;
            r_t_mp    <= res_mispredict;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < ROWS; r++)
            r_table[r] <= '0;
      end else if (r_state == UPDATE) begin
         r_table[w_t_idx] <= w_new_row;
      end
   end

   assign pred_valid = r_pred_valid;
   assign pred_taken = r_pred_taken;
   assign pred_ghr   = r_pred_ghr;

endmodule
`default_nettype wire
